// File: rtl/cpu_pkg.sv
// Shared constants, queue entry type and pc helpers for the instruction fetch front end.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] INST_NOP         = 32'h0000_0000;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } q_entry_t;

    function automatic logic [WORD_W-1:0] pc_step(input logic [WORD_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_prefetch_queue_chk.sv
// Run-time invariants of the prefetch front end; contributes no logic.
module inst_prefetch_queue_chk #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    input logic             push_i,
    input logic             full_i,
    input logic [CNT_W-1:0] outst_i,
    input logic [CNT_W-1:0] kill_i
);

    no_push_when_full: assert property (@(negedge clk) disable iff (!rst_n) !(push_i && full_i));

    kill_within_outstanding: assert property (@(negedge clk) disable iff (!rst_n) kill_i <= outst_i);

endmodule

// File: rtl/inst_queue_fifo.sv
// In-order queue of fetched {pc, inst} pairs; flush empties it in a single cycle.
module inst_queue_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  q_entry_t               entry_i,
    input  logic                   pop_i,
    output q_entry_t               head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    q_entry_t         mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] head_d;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_s;
    logic             pop_s;

    assign push_s = push_i && (count_q != DEPTH_C);
    assign pop_s  = pop_i && (count_q != {CNT_W{1'b0}});

    // Pointer and count next-state; flush overrides any push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written at the tail.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s && !flush_i) begin
            mem_q[tail_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Sequential instruction prefetcher: credit-limited memory requests, kill of stale
// responses after a redirect, and an in-order queue feeding decode.
module inst_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [WORD_W-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WORD_W-1:0]      imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [WORD_W-1:0]      imem_resp_data,
    input  logic                   redirect,
    input  logic [WORD_W-1:0]      redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_inst,
    output logic [WORD_W-1:0]      out_pc,
    output logic [WORD_W-1:0]      out_next_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] fetch_pc_q;
    logic [WORD_W-1:0] fetch_pc_d;
    logic [WORD_W-1:0] resp_pc_q;
    logic [WORD_W-1:0] resp_pc_d;
    logic [CNT_W-1:0]  outst_q;
    logic [CNT_W-1:0]  outst_d;
    logic [CNT_W-1:0]  kill_q;
    logic [CNT_W-1:0]  kill_d;

    logic [CNT_W-1:0]  count_s;
    logic [CNT_W:0]    credit_sum_s;
    logic              req_valid_s;
    logic              fire_s;
    logic              resp_ok_s;
    logic              drop_s;
    logic              push_s;
    logic              pop_s;
    logic              empty_s;
    logic              full_s;
    q_entry_t          head_s;
    q_entry_t          entry_s;

    assign credit_sum_s = {1'b0, count_s} + {1'b0, outst_q};
    // Gating with reset keeps the request low while reset is held, not just after it.
    assign req_valid_s  = reset && !redirect
                          && (credit_sum_s < (CNT_W + 1)'(DEPTH))
                          && (outst_q < CNT_W'(MAX_OUTSTANDING));
    assign fire_s       = req_valid_s && imem_req_ready;
    assign resp_ok_s    = imem_resp_valid && (outst_q != {CNT_W{1'b0}});
    assign drop_s       = resp_ok_s && (kill_q != {CNT_W{1'b0}});
    assign push_s       = resp_ok_s && (kill_q == {CNT_W{1'b0}}) && !redirect;
    assign pop_s        = !empty_s && out_ready && !redirect;
    assign entry_s      = '{pc: resp_pc_q, inst: imem_resp_data};

    // Next-state for fetch/response pcs and the outstanding/kill counters.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        kill_d     = kill_q;
        case ({fire_s, resp_ok_s})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
            // Every request still in flight belongs to the old stream; kill is already
            // a subset of outstanding, so it is replaced rather than added to.
            kill_d     = outst_d;
        end else begin
            if (fire_s) begin
                fetch_pc_d = pc_step(fetch_pc_q);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                resp_pc_d = pc_step(resp_pc_q);
            end else begin
                resp_pc_d = resp_pc_q;
            end
            if (drop_s) begin
                kill_d = kill_q - CNT_W'(1);
            end else begin
                kill_d = kill_q;
            end
        end
    end

    // Control state registers, updated on the falling edge like the pipeline registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= {CNT_W{1'b0}};
            kill_q     <= {CNT_W{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            kill_q     <= kill_d;
        end
    end

    inst_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (redirect),
        .push_i  (push_s),
        .entry_i (entry_s),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .empty_o (empty_s),
        .full_o  (full_s),
        .count_o (count_s)
    );

    inst_prefetch_queue_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_s),
        .full_i  (full_s),
        .outst_i (outst_q),
        .kill_i  (kill_q)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = !empty_s;
    assign out_inst       = empty_s ? INST_NOP : head_s.inst;
    assign out_pc         = empty_s ? 32'h0000_0000 : head_s.pc;
    assign out_next_pc    = empty_s ? 32'h0000_0000 : pc_step(head_s.pc);
    assign occupancy      = count_s;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Scoreboard bench for inst_prefetch_queue with an in-order, variable-latency memory model.
module tb_inst_prefetch_queue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int OCC_W   = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             imem_req_valid;
    logic             imem_req_ready = 1'b1;
    logic [31:0]      imem_req_addr;
    logic             imem_resp_valid = 1'b0;
    logic [31:0]      imem_resp_data = 32'h0;
    logic             redirect = 1'b0;
    logic [31:0]      redirect_pc = 32'h0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc;
    logic [31:0]      out_next_pc;
    logic [OCC_W-1:0] occupancy;

    inst_prefetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_next_pc     (out_next_pc),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    req_t        pend[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          last_due = 0;
    int          pops = 0;
    logic [31:0] model_fpc = 32'h0;
    logic [31:0] first_pop_pc = 32'hFFFF_FFFF;
    logic        arm_coincide = 1'b0;
    logic        coincide_hit = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive memory response, compare outputs against the model, then let the DUT update.
    task automatic step();
        req_t        r;
        exp_t        e;
        logic        have_resp;
        logic        exp_rv;
        int          outst_m;
        int          due;
        cyc++;
        have_resp       = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r               = pend.pop_front();
            have_resp       = 1'b1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(r.addr);
        end
        if (arm_coincide && have_resp && out_valid && out_ready && pend.size() > 0) begin
            redirect     = 1'b1;
            redirect_pc  = 32'h0000_0302;
            arm_coincide = 1'b0;
            coincide_hit = 1'b1;
        end
        #1;
        outst_m = pend.size() + (have_resp ? 1 : 0);
        exp_rv  = !redirect && (sb.size() + outst_m < DEPTH) && (outst_m < MAX_OUT);
        check_eq("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        check_eq("req_addr", imem_req_addr, model_fpc);
        check_eq("occupancy", {{(32-OCC_W){1'b0}}, occupancy}, sb.size());
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) begin
            check_eq("out_pc", out_pc, sb[0].pc);
            check_eq("out_inst", out_inst, sb[0].inst);
            check_eq("out_next_pc", out_next_pc, sb[0].pc + 32'd4);
            if (out_ready && !redirect) begin
                if (first_pop_pc == 32'hFFFF_FFFF) begin
                    first_pop_pc = sb[0].pc;
                end
                void'(sb.pop_front());
                pops++;
            end
        end else begin
            check_eq("idle_pc", out_pc, 32'h0);
            check_eq("idle_inst", out_inst, 32'h0);
        end
        if (have_resp && r.epoch == epoch && !redirect) begin
            e.pc   = r.pc;
            e.inst = mem_word(r.pc);
            sb.push_back(e);
        end
        if (redirect) begin
            sb.delete();
            epoch++;
            model_fpc = redirect_pc & 32'hFFFF_FFFC;
        end else if (imem_req_valid && imem_req_ready) begin
            due      = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            r.addr   = imem_req_addr;
            r.pc     = model_fpc;
            r.due    = due;
            r.epoch  = epoch;
            pend.push_back(r);
            model_fpc = model_fpc + 32'd4;
        end
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    // Holds reset for two clocks and clears the memory and scoreboard models with it.
    task automatic apply_reset();
        reset           = 1'b0;
        redirect        = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        sb.delete();
        pend.delete();
        epoch++;
        model_fpc = 32'h0;
        last_due  = 0;
        repeat (2) @(posedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int          p0;
        logic [31:0] hold;
        logic        reached;
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_occupancy", {{(32-OCC_W){1'b0}}, occupancy}, 32'h0);
        check_eq("rst_out_next_pc", out_next_pc, 32'h0);
        @(posedge clk);
        apply_reset();

        // Streaming with 1-cycle memory: one instruction per cycle once primed.
        lat = 1;
        out_ready = 1'b1;
        first_pop_pc = 32'hFFFF_FFFF;
        run(4);
        check_eq("stream_first_pc", first_pop_pc, 32'h0);
        p0 = pops;
        run(10);
        check_eq("stream_rate", pops - p0, 32'd10);

        // Decode stall from reset: queue fills, requests stop, then drains in order.
        apply_reset();
        out_ready = 1'b0;
        run(12);
        check_eq("stall_occupancy", {{(32-OCC_W){1'b0}}, occupancy}, 32'd4);
        check_eq("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
        out_ready = 1'b1;
        first_pop_pc = 32'hFFFF_FFFF;
        run(14);
        check_eq("drain_first_pc", first_pop_pc, 32'h0);

        // Latency 3, two requests in flight at 0x20/0x24, redirect to 0x100.
        apply_reset();
        lat = 3;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0020;
        step();
        redirect = 1'b0;
        run(2);
        check_eq("inflight_count", pend.size(), 32'd2);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        first_pop_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        run(15);
        check_eq("redir_first_pc", first_pop_pc, 32'h0000_0100);

        // Redirect on a cycle with a pop, an arriving response and another request in flight.
        apply_reset();
        lat = 2;
        out_ready = 1'b0;
        run(4);
        out_ready = 1'b1;
        arm_coincide = 1'b1;
        coincide_hit = 1'b0;
        for (int i = 0; i < 20 && !coincide_hit; i++) begin
            step();
        end
        arm_coincide = 1'b0;
        redirect = 1'b0;
        check_eq("coincide_hit", {31'b0, coincide_hit}, 32'h1);
        check_eq("coincide_empty", {{(32-OCC_W){1'b0}}, occupancy}, 32'h0);
        first_pop_pc = 32'hFFFF_FFFF;
        run(12);
        check_eq("coincide_first_pc", first_pop_pc, 32'h0000_0300);

        // Memory not ready for 5 cycles: address must hold, then resume without gaps.
        lat = 1;
        run(3);
        imem_req_ready = 1'b0;
        hold = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_addr", imem_req_addr, hold);
        end
        imem_req_ready = 1'b1;
        run(10);

        // Reset asserted mid-stream with three queued entries.
        apply_reset();
        out_ready = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step();
            reached = (occupancy == 3'd3);
        end
        check_eq("reach_occ3", {31'b0, reached}, 32'h1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("mid_rst_occupancy", {{(32-OCC_W){1'b0}}, occupancy}, 32'h0);
        check_eq("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        @(posedge clk);
        apply_reset();
        out_ready = 1'b1;
        first_pop_pc = 32'hFFFF_FFFF;
        run(8);
        check_eq("post_rst_first_pc", first_pop_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
